// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares the single write port of a fifo among
// NUM_REQ valid/ready requesters. Each grant covers one burst. A burst ends on
// the requester's last beat, when BURST_MAX beats have been written, or when
// the grantee stays idle for IDLE_TIMEOUT cycles. Each new grant costs one
// arbitration bubble cycle in IDLE.
module fifo_wr_arbiter #(
  parameter int WIDTH        = 32,
  parameter int NUM_REQ      = 4,
  parameter int BURST_MAX    = 4,
  parameter int IDLE_TIMEOUT = 8,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     w_valid,
  output logic [WIDTH-1:0]         data_in,
  output logic                     grant_valid,
  output logic [ID_W-1:0]          grant_id,
  output logic                     burst_abort
);

  // beat_cnt holds at most BURST_MAX-1; idle_cnt holds at most IDLE_TIMEOUT-1 (<= 254)
  localparam int BEAT_W = $clog2(BURST_MAX) + 1;
  localparam int IDLE_W = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                burst_abort_q, burst_abort_d;

  logic                in_grant;
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic [ID_W-1:0]     next_ptr;
  logic                beat;
  logic                last_beat;
  logic                timeout_hit;
  logic [WIDTH-1:0]    data_arr [NUM_REQ];

  assign in_grant = (state_q == S_GRANT);

  // Unpack the flat data bus into one word per requester for the output mux
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // Only the grantee may see ready, and never while the fifo is full
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = in_grant && !fifo_full && (grant_id_q == ID_W'(gi));
  end

  // Write strobe and data are combinational so a beat needs no extra latency
  always_comb begin
    w_valid = 1'b0;
    data_in = '0;
    if (in_grant) begin
      data_in = data_arr[grant_id_q];
      w_valid = req_valid[grant_id_q] && !fifo_full;
    end
  end

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite the others.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  // Release conditions and the pointer that demotes the current grantee
  always_comb begin
    next_ptr    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
    beat        = w_valid;
    last_beat   = req_last[grant_id_q] || (beat_cnt_q == BEAT_W'(BURST_MAX - 1));
    timeout_hit = (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));
  end

  // Next-state logic: arbitrate in IDLE, count beats and idleness in GRANT
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    burst_abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        if (beat) begin
          idle_cnt_d = '0;
          if (last_beat) begin
            beat_cnt_d = '0;
            rr_ptr_d   = next_ptr;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end else if (!fifo_full) begin
          // Grantee has nothing to send while the fifo could accept it
          if (timeout_hit) begin
            idle_cnt_d    = '0;
            burst_abort_d = 1'b1;
            rr_ptr_d      = next_ptr;
            state_d       = S_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
        // fifo_full stall: counters hold
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset drops any burst immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      beat_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      burst_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      beat_cnt_q    <= beat_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      burst_abort_q <= burst_abort_d;
    end
  end

  assign grant_valid = in_grant;
  assign grant_id    = grant_id_q;
  assign burst_abort = burst_abort_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter. Requesters are modelled as queues of
// tagged beats; a transaction-level reference decides who owns the write port,
// which beat goes out each cycle and when a burst ends. Asynchronous resets are
// injected mid-burst.
module tb_fifo_wr_arbiter;
  localparam int WIDTH        = 32;
  localparam int NUM_REQ      = 4;
  localparam int BURST_MAX    = 4;
  localparam int IDLE_TIMEOUT = 8;
  localparam int ID_W         = 2;
  localparam int CYCLES       = 4000;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_last = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full = 1'b0;
  logic                     w_valid;
  logic [WIDTH-1:0]         data_in;
  logic                     grant_valid;
  logic [ID_W-1:0]          grant_id;
  logic                     burst_abort;

  fifo_wr_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .w_valid(w_valid), .data_in(data_in), .grant_valid(grant_valid),
    .grant_id(grant_id), .burst_abort(burst_abort)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner of the write port (-1 = none), beats written and
  // consecutive idle cycles in the current burst, next round-robin start.
  int m_owner, m_gid, m_beats, m_idle, m_rr;
  bit m_abort;

  // Requester side
  logic [WIDTH-1:0] rq_data [NUM_REQ][$];
  bit               rq_last [NUM_REQ][$];
  bit               hold  [NUM_REQ];
  int               sleep [NUM_REQ];
  int               seq   [NUM_REQ];
  int               full_run;
  int               rst_at;

  logic [NUM_REQ-1:0] exp_ready;
  logic               exp_wv;
  logic [WIDTH-1:0]   exp_data;

  task automatic model_reset();
    m_owner = -1; m_gid = 0; m_beats = 0; m_idle = 0; m_rr = 0; m_abort = 1'b0;
  endtask

  initial begin
    model_reset();
    full_run = 0;
    rst_at   = 300;
    for (int i = 0; i < NUM_REQ; i++) begin
      hold[i] = 1'b0; sleep[i] = 0; seq[i] = 0;
    end

    // Held in reset: everything quiet even with every requester valid
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    check_val("rst_grant_valid", grant_valid, 0);
    check_val("rst_burst_abort", burst_abort, 0);
    check_val("rst_grant_id", grant_id, 0);
    check_val("rst_w_valid", w_valid, 0);
    check_val("rst_req_ready", req_ready, 0);
    check_val("rst_data_in", data_in, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      // Registered outputs reflect the model state after the last edge
      check_val("grant_valid", grant_valid, m_owner >= 0);
      check_val("grant_id", grant_id, m_gid);
      check_val("burst_abort", burst_abort, m_abort);

      // Refill requester queues with tagged beats
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq_data[i].size() < 3 && $urandom_range(0, 2) == 0) begin
          rq_data[i].push_back({8'(i), 24'(seq[i])});
          rq_last[i].push_back($urandom_range(0, 3) == 0);
          seq[i]++;
        end
      end

      // fifo_full: occasional multi-cycle runs plus sparse single cycles
      if (full_run > 0) begin
        fifo_full = 1'b1;
        full_run--;
      end else if ($urandom_range(0, 24) == 0) begin
        fifo_full = 1'b1;
        full_run  = $urandom_range(0, 4);
      end else begin
        fifo_full = ($urandom_range(0, 9) == 0);
      end

      // Requesters: once valid is shown it is held until accepted
      for (int i = 0; i < NUM_REQ; i++) begin
        bit show;
        show = 1'b0;
        if (sleep[i] > 0) begin
          sleep[i]--;
        end else begin
          show = (rq_data[i].size() > 0) && (hold[i] || $urandom_range(0, 3) != 0);
        end
        req_valid[i] = show;
        if (show) begin
          hold[i] = 1'b1;
          req_data[i*WIDTH +: WIDTH] = rq_data[i][0];
          req_last[i] = rq_last[i][0];
        end else begin
          req_data[i*WIDTH +: WIDTH] = $urandom;
          req_last[i] = $urandom_range(0, 1) == 1;
        end
      end
      #1;

      // Expected combinational outputs
      exp_ready = '0;
      exp_wv    = 1'b0;
      exp_data  = '0;
      if (m_owner >= 0) begin
        exp_data = req_data[m_owner*WIDTH +: WIDTH];
        if (!fifo_full) begin
          exp_ready[m_owner] = 1'b1;
          exp_wv = req_valid[m_owner];
        end
      end
      check_val("w_valid", w_valid, exp_wv);
      check_val("req_ready", req_ready, exp_ready);
      check_val("data_in", data_in, exp_data);
      if (exp_wv) begin
        check_val("beat_order", data_in, rq_data[m_owner][0]);
      end

      // Asynchronous reset in the middle of a write beat
      if (cyc >= rst_at && exp_wv) begin
        reset = 1'b1;
        #1;
        check_val("arst_w_valid", w_valid, 0);
        check_val("arst_req_ready", req_ready, 0);
        check_val("arst_grant_valid", grant_valid, 0);
        check_val("arst_data_in", data_in, 0);
        $display("reset injected mid-burst of req=%0d after %0d beats", m_owner, m_beats);
        model_reset();
        rst_at = rst_at + 1000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        continue;
      end

      // Model advance across the coming edge
      m_abort = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int r;
          r = (m_rr + k) % NUM_REQ;
          if (req_valid[r]) begin
            m_owner = r; m_gid = r; m_beats = 0; m_idle = 0;
            break;
          end
        end
      end else if (exp_wv) begin
        bit was_last;
        was_last = req_last[m_owner];
        void'(rq_data[m_owner].pop_front());
        void'(rq_last[m_owner].pop_front());
        hold[m_owner] = 1'b0;
        if ($urandom_range(0, 5) == 0) sleep[m_owner] = $urandom_range(1, 12);
        m_beats++;
        m_idle = 0;
        if (was_last || m_beats == BURST_MAX) begin
          $display("burst req=%0d beats=%0d end=%s", m_owner, m_beats, was_last ? "last" : "max");
          m_rr = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end
      end else if (!fifo_full) begin
        m_idle++;
        if (m_idle == IDLE_TIMEOUT) begin
          $display("burst req=%0d beats=%0d end=timeout", m_owner, m_beats);
          m_abort = 1'b1;
          m_rr = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end
      end

      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
